// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings, RV32I opcodes and funct7 values.
// Imported by both the ALU and the decode stage so the two cannot drift apart.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD     = 4'b0000,
    ALU_SUB     = 4'b0001,
    ALU_SLL     = 4'b0010,
    ALU_SLT     = 4'b0011,
    ALU_SLTU    = 4'b0100,
    ALU_XOR     = 4'b0101,
    ALU_SRL     = 4'b0110,
    ALU_SRA     = 4'b0111,
    ALU_OR      = 4'b1000,
    ALU_AND     = 4'b1001,
    ALU_INVALID = 4'b1111
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Operation for the funct7=0000000 flavour of funct3; OP and OP-IMM share it.
  function automatic alu_op_e base_ctrl(input logic [2:0] funct3);
    alu_op_e op;
    case (funct3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate extraction for the I- and U-type formats.
// Only instr[31:12] is needed; the port keeps the instruction's own bit numbering.
module imm_gen #(
  parameter int XLEN = 32
) (
  input  logic [31:12]     instr_hi,
  output logic [XLEN-1:0]  imm_i,
  output logic [XLEN-1:0]  imm_u,
  output logic [XLEN-1:0]  imm_sh
);

  assign imm_i  = XLEN'($signed(instr_hi[31:20]));
  assign imm_u  = XLEN'($signed({instr_hi[31:12], 12'b0}));
  assign imm_sh = XLEN'(instr_hi[24:20]);

endmodule

// File: rtl/alu_op_decoder.sv
// RV32I OP/OP-IMM/LUI/AUIPC decode and issue register toward the ALU, valid/ready on both sides.
// Define ALU_DEC_SKID_EN for a 2-entry skid buffer with registered in_ready.
module alu_op_decoder
  import alu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   op_a,
  output logic [XLEN-1:0]   op_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [4:0]        rd,
  output logic              reg_write,
  output logic              illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] dec_rd;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign dec_rd = instr[11:7];

  logic [XLEN-1:0] imm_i, imm_u, imm_sh;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr_hi (instr[31:12]),
    .imm_i    (imm_i),
    .imm_u    (imm_u),
    .imm_sh   (imm_sh)
  );

  logic [XLEN-1:0]   dec_a, dec_b;
  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_illegal;
  logic              dec_we;

  always_comb begin
    dec_illegal = 1'b1;
    dec_ctrl    = CTRL_W'(ALU_INVALID);
    dec_a       = '0;
    dec_b       = '0;
    case (opcode)
      OPC_OP_IMM: begin
        dec_illegal = 1'b0;
        dec_ctrl    = CTRL_W'(base_ctrl(funct3));
        dec_a       = rs1_data;
        dec_b       = imm_i;
        // Shift immediates carry funct7 in imm[11:5]; only shamt reaches the ALU.
        if (funct3 == 3'b001) begin
          dec_b       = imm_sh;
          dec_illegal = (funct7 != F7_BASE);
        end else if (funct3 == 3'b101) begin
          dec_b = imm_sh;
          if (funct7 == F7_ALT) begin
            dec_ctrl = CTRL_W'(ALU_SRA);
          end else if (funct7 != F7_BASE) begin
            dec_illegal = 1'b1;
          end
        end
      end
      OPC_OP: begin
        dec_a = rs1_data;
        dec_b = rs2_data;
        if (funct7 == F7_BASE) begin
          dec_illegal = 1'b0;
          dec_ctrl    = CTRL_W'(base_ctrl(funct3));
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          dec_illegal = 1'b0;
          dec_ctrl    = CTRL_W'(ALU_SUB);
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          dec_illegal = 1'b0;
          dec_ctrl    = CTRL_W'(ALU_SRA);
        end
      end
      OPC_LUI: begin
        dec_illegal = 1'b0;
        dec_ctrl    = CTRL_W'(ALU_ADD);
        dec_b       = imm_u;
      end
      OPC_AUIPC: begin
        dec_illegal = 1'b0;
        dec_ctrl    = CTRL_W'(ALU_ADD);
        dec_a       = pc;
        dec_b       = imm_u;
      end
      default: ;
    endcase
    if (dec_illegal) begin
      dec_ctrl = CTRL_W'(ALU_INVALID);
      dec_a    = '0;
      dec_b    = '0;
    end
    dec_we = !dec_illegal && (dec_rd != 5'd0);
  end

  logic capture;
  logic main_load;
  logic ld_valid;
  logic [XLEN-1:0]   ld_a, ld_b;
  logic [CTRL_W-1:0] ld_ctrl;
  logic [4:0]        ld_rd;
  logic              ld_we, ld_illegal;

  assign capture   = in_valid && in_ready;
  assign main_load = !out_valid || out_ready;

`ifdef ALU_DEC_SKID_EN
  logic              skid_valid;
  logic [XLEN-1:0]   skid_a, skid_b;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [4:0]        skid_rd;
  logic              skid_we, skid_illegal;

  // Accept whenever the skid slot is free, regardless of this cycle's out_ready.
  assign in_ready = !skid_valid && !flush;

  assign ld_valid   = skid_valid || capture;
  assign ld_a       = skid_valid ? skid_a       : dec_a;
  assign ld_b       = skid_valid ? skid_b       : dec_b;
  assign ld_ctrl    = skid_valid ? skid_ctrl    : dec_ctrl;
  assign ld_rd      = skid_valid ? skid_rd      : dec_rd;
  assign ld_we      = skid_valid ? skid_we      : dec_we;
  assign ld_illegal = skid_valid ? skid_illegal : dec_illegal;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      skid_valid <= 1'b0;
    end else if (main_load) begin
      skid_valid <= 1'b0;
    end else if (capture) begin
      skid_valid   <= 1'b1;
      skid_a       <= dec_a;
      skid_b       <= dec_b;
      skid_ctrl    <= dec_ctrl;
      skid_rd      <= dec_rd;
      skid_we      <= dec_we;
      skid_illegal <= dec_illegal;
    end
  end
`else
  assign in_ready = !flush && (!out_valid || out_ready);

  assign ld_valid   = capture;
  assign ld_a       = dec_a;
  assign ld_b       = dec_b;
  assign ld_ctrl    = dec_ctrl;
  assign ld_rd      = dec_rd;
  assign ld_we      = dec_we;
  assign ld_illegal = dec_illegal;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      alu_ctrl  <= CTRL_W'(ALU_INVALID);
      rd        <= 5'd0;
      reg_write <= 1'b0;
      illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (main_load) begin
      out_valid <= ld_valid;
      if (ld_valid) begin
        op_a      <= ld_a;
        op_b      <= ld_b;
        alu_ctrl  <= ld_ctrl;
        rd        <= ld_rd;
        reg_write <= ld_we;
        illegal   <= ld_illegal;
      end
    end
  end

endmodule

// File: tb/tb_alu_op_decoder.sv
// Directed self-checking bench for alu_op_decoder (either skid configuration).
module tb_alu_op_decoder;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [3:0]  alu_ctrl;
  logic [4:0]  rd;
  logic        reg_write;
  logic        illegal;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } vec_t;

  alu_op_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .pc        (pc),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .alu_ctrl  (alu_ctrl),
    .rd        (rd),
    .reg_write (reg_write),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] addi_word(input int rdn, input int imm);
    logic [31:0] w;
    w = {12'(imm), 5'd0, 3'b000, 5'(rdn), 7'h13};
    return w;
  endfunction

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instr = 32'h0; pc = 32'h0; rs1_data = 32'h0; rs2_data = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || op_a !== 32'h0 || op_b !== 32'h0 || alu_ctrl !== 4'hF ||
        rd !== 5'd0 || reg_write !== 1'b0 || illegal !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: got valid=%b a=%h b=%h ctrl=%h rd=%0d we=%b ill=%b, need 0 0 0 f 0 0 0",
               out_valid, op_a, op_b, alu_ctrl, rd, reg_write, illegal);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b need 1", in_ready);
    end
  endtask

  task automatic test_decode_table();
    vec_t v[17];
    v[0]  = '{32'h00A00093, 32'h0, 32'h0,        32'h0,  32'h0,        32'd10,       4'h0, 5'd1, 1'b1, 1'b0};
    v[1]  = '{32'h402081B3, 32'h0, 32'd20,       32'd20, 32'd20,       32'd20,       4'h1, 5'd3, 1'b1, 1'b0};
    v[2]  = '{32'h40235293, 32'h0, 32'h80000000, 32'h0,  32'h80000000, 32'd2,        4'h7, 5'd5, 1'b1, 1'b0};
    v[3]  = '{32'h123453B7, 32'h0, 32'hDEADBEEF, 32'h1,  32'h0,        32'h12345000, 4'h0, 5'd7, 1'b1, 1'b0};
    v[4]  = '{32'h0000006F, 32'h0, 32'h55,       32'h66, 32'h0,        32'h0,        4'hF, 5'd0, 1'b0, 1'b1};
    v[5]  = '{32'h00100013, 32'h0, 32'h0,        32'h0,  32'h0,        32'd1,        4'h0, 5'd0, 1'b0, 1'b0};
    v[6]  = '{32'hFFFFF217, 32'h1000, 32'h77,    32'h0,  32'h1000,     32'hFFFFF000, 4'h0, 5'd4, 1'b1, 1'b0};
    v[7]  = '{32'hFFF08113, 32'h0, 32'd7,        32'h0,  32'd7,        32'hFFFFFFFF, 4'h0, 5'd2, 1'b1, 1'b0};
    v[8]  = '{32'h0083F333, 32'h0, 32'hF0F0,     32'h0FF0, 32'hF0F0,   32'h0FF0,     4'h9, 5'd6, 1'b1, 1'b0};
    v[9]  = '{32'h003130B3, 32'h0, 32'd1,        32'd2,  32'd1,        32'd2,        4'h4, 5'd1, 1'b1, 1'b0};
    v[10] = '{32'h02009093, 32'h0, 32'd3,        32'h0,  32'h0,        32'h0,        4'hF, 5'd1, 1'b0, 1'b1};
    v[11] = '{32'h40209033, 32'h0, 32'd3,        32'd4,  32'h0,        32'h0,        4'hF, 5'd0, 1'b0, 1'b1};
    v[12] = '{32'h01F09093, 32'h0, 32'd1,        32'h0,  32'd1,        32'd31,       4'h2, 5'd1, 1'b1, 1'b0};
    v[13] = '{32'h00235293, 32'h0, 32'h80000000, 32'h0,  32'h80000000, 32'd2,        4'h6, 5'd5, 1'b1, 1'b0};
    v[14] = '{32'h7FF26193, 32'h0, 32'h1234,     32'h0,  32'h1234,     32'h7FF,      4'h8, 5'd3, 1'b1, 1'b0};
    v[15] = '{32'h003140B3, 32'h0, 32'hAA,       32'h55, 32'hAA,       32'h55,       4'h5, 5'd1, 1'b1, 1'b0};
    v[16] = '{32'h4030D0B3, 32'h0, 32'h8000_0000, 32'd4, 32'h80000000, 32'd4,        4'h7, 5'd1, 1'b1, 1'b0};
    out_ready = 1'b1;
    foreach (v[i]) begin
      @(negedge clk);
      in_valid = 1'b1; instr = v[i].instr; pc = v[i].pc;
      rs1_data = v[i].rs1; rs2_data = v[i].rs2;
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1) begin
        failures++;
        $display("FAIL decode_valid[%0d]: got out_valid=%b need 1", i, out_valid);
      end
      checks++;
      if (op_a !== v[i].a || op_b !== v[i].b || alu_ctrl !== v[i].ctrl || rd !== v[i].rd ||
          reg_write !== v[i].we || illegal !== v[i].ill) begin
        failures++;
        $display("FAIL decode[%0d] instr=%h: got a=%h b=%h ctrl=%h rd=%0d we=%b ill=%b need a=%h b=%h ctrl=%h rd=%0d we=%b ill=%b",
                 i, v[i].instr, op_a, op_b, alu_ctrl, rd, reg_write, illegal,
                 v[i].a, v[i].b, v[i].ctrl, v[i].rd, v[i].we, v[i].ill);
      end
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i < 3) begin
        in_valid = 1'b1; instr = addi_word(13 + i, 40 + i); rs1_data = 32'h0;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (i < 3) begin
        checks++;
        if (in_ready !== 1'b1) begin
          failures++;
          $display("FAIL b2b_in_ready[%0d]: got %b need 1", i, in_ready);
        end
      end
      if (i > 0) begin
        checks++;
        if (out_valid !== 1'b1 || rd !== 5'(12 + i) || op_b !== 32'(39 + i)) begin
          failures++;
          $display("FAIL b2b_out[%0d]: got valid=%b rd=%0d b=%0d need 1 %0d %0d",
                   i, out_valid, rd, op_b, 12 + i, 39 + i);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int c = 0;
    int r = 0;
    logic stalled_prev = 1'b0;
    logic [31:0] snap_a = '0, snap_b = '0;
    logic [3:0]  snap_ctrl = '0;
    logic [4:0]  snap_rd = '0;
    logic        exp_ready;
    for (int cyc = 0; cyc < 40 && r < 4; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 2 && cyc <= 4);
      in_valid  = (c < 4);
      instr     = addi_word(c + 1, c + 1);
      rs1_data  = 32'((c + 1) * 100);
      #1;
      if (stalled_prev) begin
        checks++;
        if (op_a !== snap_a || op_b !== snap_b || alu_ctrl !== snap_ctrl || rd !== snap_rd) begin
          failures++;
          $display("FAIL bp_hold cyc%0d: got a=%h b=%h ctrl=%h rd=%0d need a=%h b=%h ctrl=%h rd=%0d",
                   cyc, op_a, op_b, alu_ctrl, rd, snap_a, snap_b, snap_ctrl, snap_rd);
        end
      end
`ifdef ALU_DEC_SKID_EN
      exp_ready = (c - r) < 2;
`else
      exp_ready = ((c - r) == 0) || out_ready;
`endif
      checks++;
      if (in_ready !== exp_ready) begin
        failures++;
        $display("FAIL bp_in_ready cyc%0d: got %b need %b", cyc, in_ready, exp_ready);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (rd !== 5'(r + 1) || op_b !== 32'(r + 1) || op_a !== 32'((r + 1) * 100) ||
            alu_ctrl !== 4'h0) begin
          failures++;
          $display("FAIL bp_order word%0d: got rd=%0d a=%0d b=%0d ctrl=%h need rd=%0d a=%0d b=%0d ctrl=0",
                   r, rd, op_a, op_b, alu_ctrl, r + 1, (r + 1) * 100, r + 1);
        end
        r++;
      end
      if (in_valid && in_ready) c++;
      stalled_prev = out_valid && !out_ready;
      snap_a = op_a; snap_b = op_b; snap_ctrl = alu_ctrl; snap_rd = rd;
    end
    in_valid = 1'b0;
    checks++;
    if (r != 4 || c != 4) begin
      failures++;
      $display("FAIL bp_timeout: got retired=%0d captured=%0d need 4 4", r, c);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_no_dup: got out_valid=%b rd=%0d need 0", out_valid, rd);
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; instr = addi_word(9, 9); rs1_data = 32'h0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || rd !== 5'd9) begin
      failures++;
      $display("FAIL flush_setup: got valid=%b rd=%0d need 1 9", out_valid, rd);
    end
    flush = 1'b1; in_valid = 1'b1; instr = addi_word(10, 10);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_in_ready: got %b need 0", in_ready);
    end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_kill: got out_valid=%b need 0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_empty: got in_ready=%b need 1", in_ready);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_no_capture: got out_valid=%b rd=%0d need 0", out_valid, rd);
    end
  endtask

  task automatic test_reset_mid_stall();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; instr = addi_word(11, 11); rs1_data = 32'h5;
    @(negedge clk);
    instr = addi_word(12, 12);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || rd !== 5'd11) begin
      failures++;
      $display("FAIL rst_stall_setup: got valid=%b rd=%0d need 1 11", out_valid, rd);
    end
    rst = 1'b1; flush = 1'b1;
    @(negedge clk);
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || op_a !== 32'h0 || op_b !== 32'h0 || alu_ctrl !== 4'hF ||
        rd !== 5'd0 || reg_write !== 1'b0 || illegal !== 1'b0) begin
      failures++;
      $display("FAIL rst_stall_values: got valid=%b a=%h b=%h ctrl=%h rd=%0d we=%b ill=%b need 0 0 0 f 0 0 0",
               out_valid, op_a, op_b, alu_ctrl, rd, reg_write, illegal);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_stall_drop: got out_valid=%b rd=%0d need 0", out_valid, rd);
    end
  endtask

  initial begin
    test_reset();
    test_decode_table();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
